cross_bar_arbiter: RTL and testbench
====================================

// Module: cross_bar_arbiter
// PURPOSE
// - Per-slave round-robin arbiter; one instance per slave port, sits directly upstream of the cross-bar muxes.
// - Decodes each master's address and selects one requesting master for slave SLAVE_ID.
// - Holds the selected grant until the slave acks the transfer.
// - grant_num drives the cross-bar slave-side select (master_num[SLAVE_ID]).
// - grant_onehot lets the top build the master-side select (slave_num).
// PARAMETERS
// - SLAVE_ID        0    index of the slave this instance serves (0..SLAVE_N-1)
// - TIMEOUT_CYCLES  256  BUSY cycles without ack before forced release (only with CROSS_BAR_ARB_TIMEOUT_EN)
// - MASTER_N, MASTER_W, SLAVE_N, SLAVE_W, ADDR_W: localparams taken from cross_bar_pkg; SLAVE_N >= 2
// PORTS
// - clk           in   1                  clock, all state on rising edge
// - aresetn       in   1                  asynchronous active-low reset
// - master_req    in   MASTER_N           per-master request, held high until that master sees ack
// - master_addr   in   MASTER_N x addr_t  per-master address
// - slave_ack     in   1                  ack from slave SLAVE_ID, single-cycle pulse
// - slave_req_o   out  1                  gated request to slave SLAVE_ID
// - grant_valid   out  1                  a master currently owns this slave
// - grant_num     out  MASTER_W           index of the owning master
// - grant_onehot  out  MASTER_N           one-hot owner; all zero when grant_valid=0
// - timeout_err   out  1                  one-cycle pulse on forced release
// BEHAVIOUR
// - Request decode: hit[m] = master_req[m] && (master_addr[m][ADDR_W-1 -: SLAVE_W] == SLAVE_ID).
// - Reset: state IDLE; last_grant = MASTER_N-1, so master 0 has first priority.
// - Reset values: grant_valid=0, grant_num=0, grant_onehot=0, slave_req_o=0, timeout_err=0, timer=0.
// - Reset is honoured mid-transaction: all outputs clear at once, with no completion of the in-flight transfer.
// - FSM IDLE -> BUSY: when any hit[] is set, register winner w.
//   - w = first set hit[] searching from (last_grant+1) mod MASTER_N upward, wrapping.
//   - In the same edge: grant_num=w, grant_onehot=1<<w, grant_valid=1.
//   - Latency: master_req to slave_req_o is exactly 1 cycle.
// - In BUSY: slave_req_o = master_req[grant_num] (combinational from the registered grant).
//   - Other masters' requests are ignored.
// - BUSY -> IDLE on slave_ack=1:
//   - last_grant <= grant_num; grant_valid, grant_onehot and grant_num clear on the next edge.
//   - Exactly one IDLE bubble cycle follows before the next grant, even with requests pending.
// - BUSY -> IDLE when master_req[grant_num] drops without ack (abort):
//   - Same as ack, but last_grant is unchanged.
// - Simultaneous ack and owner req drop: treated as ack.
// - slave_ack while IDLE: ignored, no state change.
// - Address change by the owner while BUSY: ignored; the grant is not re-decoded until IDLE.
// - Fairness: with all masters requesting continuously, each is granted once per MASTER_N transactions.
// CONFIGURATION
// - Macro CROSS_BAR_ARB_TIMEOUT_EN defined:
//   - A $clog2(TIMEOUT_CYCLES+1)-bit timer is cleared on entry to BUSY and counts each BUSY cycle without ack.
//   - When the timer reaches TIMEOUT_CYCLES, the arbiter goes to IDLE with last_grant <= grant_num.
//   - timeout_err=1 for that single cycle; the timer saturates and never wraps.
//   - An ack in the same cycle as expiry wins: no error pulse.
// - Macro not defined: no timer logic, timeout_err tied to 0, BUSY waits for ack or abort indefinitely.
// TESTING (MASTER_N=4, SLAVE_N=4, SLAVE_ID=1, TIMEOUT_CYCLES=8)
// - Reset: hold aresetn=0 with random inputs -> all outputs 0; release -> still 0 until a hit.
// - Single request: cycle 0 master 2 req, addr targets slave 1; ack at cycle 4.
//   -> cycle 1: grant_num=2, onehot=4'b0100, slave_req_o=1.
//   -> cycle 5: grant_valid=0.
// - Round robin: masters 0, 1 and 3 hit continuously, ack 2 cycles after each grant -> grant order 0,1,3,0,1 with one bubble between grants.
// - Decode: master 0 requests slave 2 address only -> no grant, slave_req_o stays 0 for 20 cycles.
// - Reset mid-BUSY: grant to master 3, aresetn pulsed low -> outputs 0 immediately; with masters 0 and 3 then requesting, master 0 is granted first.
// - Timeout (macro on): grant, no ack -> timeout_err=1 for 1 cycle at BUSY cycle 8, grant_valid=0 next edge.
// - Macro off: same stimulus -> grant is held, timeout_err stays 0.

Source files
------------

// File: rtl/cross_bar_arbiter.sv
// rtl/cross_bar_arbiter.sv - per-slave round-robin arbiter feeding the cross-bar select muxes
// Optional forced-release timer is compiled in with CROSS_BAR_ARB_TIMEOUT_EN.
package cross_bar_pkg;
  localparam int MASTER_N = 4;
  localparam int MASTER_W = $clog2(MASTER_N);
  localparam int SLAVE_N  = 4;
  localparam int SLAVE_W  = $clog2(SLAVE_N);
  localparam int ADDR_W   = 16;

  typedef logic [ADDR_W-1:0] addr_t;
endpackage

module cross_bar_arbiter
  import cross_bar_pkg::*;
#(
  parameter int SLAVE_ID       = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [MASTER_N-1:0]  master_req,
  input  addr_t [MASTER_N-1:0] master_addr,
  input  logic                 slave_ack,
  output logic                 slave_req_o,
  output logic                 grant_valid,
  output logic [MASTER_W-1:0]  grant_num,
  output logic [MASTER_N-1:0]  grant_onehot,
  output logic                 timeout_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [SLAVE_W-1:0] SLAVE_SEL = SLAVE_W'(SLAVE_ID);

  state_t              state_q;
  state_t              state_d;
  logic [MASTER_W-1:0] grant_q;
  logic [MASTER_W-1:0] grant_d;
  logic [MASTER_W-1:0] last_q;
  logic [MASTER_W-1:0] last_d;
  logic [MASTER_W-1:0] winner;
  logic [MASTER_W-1:0] cand;
  logic                winner_found;
  logic [MASTER_N-1:0] hit;
  logic                owner_req;
  logic                expire;
  logic                addr_unused;

  // Only the slave-select field of each address matters here.
  assign addr_unused = ^master_addr;

  always_comb begin
    hit = '0;
    for (int m = 0; m < MASTER_N; m++) begin
      hit[m] = master_req[m] && (master_addr[m][ADDR_W-1 -: SLAVE_W] == SLAVE_SEL);
    end
  end

  // Search starts one past the last completed owner and wraps.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int i = 1; i <= MASTER_N; i++) begin
      cand = MASTER_W'((int'(last_q) + i) % MASTER_N);
      if (!winner_found && hit[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  assign owner_req = master_req[grant_q];

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      timer_q <= '0;
    end else if (state_q != BUSY) begin
      timer_q <= '0;
    end else if (!slave_ack && (timer_q != TMR_MAX)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Fires in the BUSY cycle that brings the count to TIMEOUT_CYCLES; an ack there wins.
  assign expire = (state_q == BUSY) && !slave_ack && owner_req && (timer_q == TMR_LAST);
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (winner_found) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (slave_ack || expire) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = grant_q;
        end else if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= MASTER_W'(MASTER_N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_valid  = (state_q == BUSY);
  assign grant_num    = grant_q;
  assign grant_onehot = grant_valid ? (MASTER_N'(1) << grant_q) : '0;
  assign slave_req_o  = grant_valid && owner_req;
  assign timeout_err  = expire;

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// tb/tb_cross_bar_arbiter.sv - randomized and directed bench for cross_bar_arbiter against a behavioural model
module tb_cross_bar_arbiter;
  import cross_bar_pkg::*;

  localparam int SID = 1;
  localparam int TMO = 8;

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic [MASTER_N-1:0]  master_req;
  addr_t [MASTER_N-1:0] master_addr;
  logic                 slave_ack;
  logic                 slave_req_o;
  logic                 grant_valid;
  logic [MASTER_W-1:0]  grant_num;
  logic [MASTER_N-1:0]  grant_onehot;
  logic                 timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  int m_owner;
  int m_last;
  int m_busy;
  bit tmo_on;

  always #5 clk = ~clk;

  cross_bar_arbiter #(
    .SLAVE_ID      (SID),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .master_req  (master_req),
    .master_addr (master_addr),
    .slave_ack   (slave_ack),
    .slave_req_o (slave_req_o),
    .grant_valid (grant_valid),
    .grant_num   (grant_num),
    .grant_onehot(grant_onehot),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic addr_t mk_addr(input int slv);
    addr_t a;
    a = addr_t'($urandom);
    a[ADDR_W-1 -: SLAVE_W] = SLAVE_W'(slv);
    return a;
  endfunction

  function automatic bit is_hit(input int m);
    return master_req[m] && (int'(master_addr[m][ADDR_W-1 -: SLAVE_W]) == SID);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = MASTER_N - 1;
    m_busy  = 0;
  endtask

  // Called #1 after a rising edge with inputs driven; checks at the falling edge, advances the model.
  task automatic cycle();
    bit own_req;
    bit exp_terr;
    int c;
    @(negedge clk);
    if (!aresetn) model_reset();
    own_req  = (m_owner >= 0) && master_req[m_owner];
    exp_terr = tmo_on && own_req && !slave_ack && (m_busy + 1 == TMO);
    check("grant_valid", grant_valid, m_owner >= 0);
    check("grant_num", grant_num, (m_owner >= 0) ? m_owner : 0);
    check("grant_onehot", grant_onehot, (m_owner >= 0) ? (1 << m_owner) : 0);
    check("slave_req_o", slave_req_o, own_req);
    check("timeout_err", timeout_err, exp_terr);
    if (aresetn) begin
      if (m_owner < 0) begin
        for (int k = 1; k <= MASTER_N && m_owner < 0; k++) begin
          c = (m_last + k) % MASTER_N;
          if (is_hit(c)) begin
            m_owner = c;
            m_busy  = 0;
          end
        end
      end else if (slave_ack || exp_terr) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (!own_req) begin
        m_owner = -1;
      end else begin
        m_busy++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[5] = '{0, 1, 3, 0, 1};
    int gr_seq[5];
    int gr_gap[5];
    int n_gr;
    int idle_run;
    bit prev_gv;
    bit seen;
    int busy_idx;
    int t_pulses;
    int t_at;
    int acked_m;

    tmo_on = 1'b0;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    tmo_on = 1'b1;
`endif
    aresetn    = 1'b0;
    slave_ack  = 1'b0;
    master_req = '0;
    for (int m = 0; m < MASTER_N; m++) master_addr[m] = '0;
    model_reset();
    #1;

    // reset held with random inputs
    repeat (5) begin
      master_req = MASTER_N'($urandom);
      for (int m = 0; m < MASTER_N; m++) master_addr[m] = mk_addr(int'($urandom_range(0, 3)));
      slave_ack = 1'($urandom_range(0, 1));
      #1;
      check("reset_outputs", {slave_req_o, grant_valid, grant_num, grant_onehot, timeout_err}, 0);
      cycle();
    end
    aresetn    = 1'b1;
    master_req = '0;
    slave_ack  = 1'b0;
    repeat (3) cycle();
    check("post_reset_idle", {slave_req_o, grant_valid, grant_num, grant_onehot}, 0);

    // round robin: masters 0,1,3 hit continuously, master 2 targets another slave
    master_addr[0] = mk_addr(SID);
    master_addr[1] = mk_addr(SID);
    master_addr[2] = mk_addr(3);
    master_addr[3] = mk_addr(SID);
    master_req     = 4'b1111;
    prev_gv  = 1'b0;
    idle_run = 0;
    n_gr     = 0;
    for (int t = 0; t < 60 && n_gr < 5; t++) begin
      slave_ack = (m_owner >= 0) && (m_busy == 1);
      cycle();
      if (grant_valid && !prev_gv) begin
        gr_seq[n_gr] = int'(grant_num);
        gr_gap[n_gr] = idle_run;
        n_gr++;
        idle_run = 0;
      end else if (!grant_valid) begin
        idle_run++;
      end
      prev_gv = grant_valid;
    end
    check("rr_grant_count", n_gr, 5);
    for (int i = 0; i < n_gr; i++) begin
      check("rr_order", gr_seq[i], exp_seq[i]);
      if (i > 0) check("rr_bubble", gr_gap[i], 1);
    end
    slave_ack  = 1'b0;
    master_req = '0;
    repeat (3) cycle();

    // single request from master 2, ack in cycle 4
    master_addr[2] = mk_addr(SID);
    master_req     = 4'b0100;
    cycle();
    check("single_grant_num", grant_num, 2);
    check("single_onehot", grant_onehot, 4'b0100);
    check("single_slave_req", slave_req_o, 1);
    repeat (3) cycle();
    slave_ack = 1'b1;
    cycle();
    slave_ack  = 1'b0;
    master_req = '0;
    check("single_release", grant_valid, 0);
    repeat (2) cycle();

    // decode: master 0 targets slave 2 only
    master_addr[0] = mk_addr(2);
    master_req     = 4'b0001;
    seen = 1'b0;
    repeat (20) begin
      cycle();
      seen = seen | slave_req_o | grant_valid;
    end
    check("decode_no_grant", seen, 0);
    master_req = '0;
    cycle();

    // reset mid-BUSY
    master_addr[3] = mk_addr(SID);
    master_req     = 4'b1000;
    cycle();
    check("rmid_grant", grant_num, 3);
    cycle();
    aresetn        = 1'b0;
    master_addr[0] = mk_addr(SID);
    master_req     = 4'b1001;
    #1;
    check("rmid_clear", {slave_req_o, grant_valid, grant_num, grant_onehot}, 0);
    cycle();
    aresetn = 1'b1;
    cycle();
    check("rmid_first_valid", grant_valid, 1);
    check("rmid_first_num", grant_num, 0);
    slave_ack = 1'b1;
    cycle();
    slave_ack  = 1'b0;
    master_req = '0;
    repeat (2) cycle();

    // timeout: owner never acked
    master_addr[1] = mk_addr(SID);
    master_req     = 4'b0010;
    busy_idx = 0;
    t_pulses = 0;
    t_at     = 0;
    for (int t = 0; t < 14; t++) begin
      if (grant_valid) busy_idx++;
      if (timeout_err) begin
        t_pulses++;
        t_at = busy_idx;
      end
      cycle();
    end
    if (tmo_on) begin
      check("tmo_pulses", t_pulses, 1);
      check("tmo_busy_cycle", t_at, TMO);
    end else begin
      check("tmo_pulses", t_pulses, 0);
      check("tmo_grant_held", grant_valid, 1);
    end
    master_req = '0;
    repeat (2) cycle();

    // randomized traffic
    acked_m = -1;
    for (int t = 0; t < 500; t++) begin
      for (int m = 0; m < MASTER_N; m++) begin
        if (master_req[m]) begin
          if (acked_m == m || $urandom_range(0, 15) == 0) master_req[m] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          master_req[m]  = 1'b1;
          master_addr[m] = mk_addr(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : SID);
        end
        if ($urandom_range(0, 7) == 0) master_addr[m] = mk_addr(int'($urandom_range(0, 3)));
      end
      slave_ack = (m_owner >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      acked_m   = (slave_ack && m_owner >= 0) ? m_owner : -1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
